// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types and constants for the instruction cache
// Purpose: line geometry constants and the icache FSM state encoding.
// Ports: none (package).
package rv32i_types;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - flop-based valid/tag/data storage for the icache
// Purpose: per-set valid bit, tag and line; one combinational read port and
//          one write port. Reset clears valid bits only.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rd_index          set to read
//   rd_valid/tag/line contents of rd_index (combinational)
//   wr_en/index/tag/line  install a line and mark it valid
import rv32i_types::*;

module icache_array #(
  parameter int SETS     = 16,
  parameter int IDX_BITS = $clog2(SETS),
  parameter int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_BITS-1:0]  rd_index,
  output logic                 rd_valid,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_line
);

  logic [SETS-1:0]      valid;
  logic [TAG_BITS-1:0]  tags  [SETS];
  logic [LINE_BITS-1:0] lines [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tags and data are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache
// Purpose: serves word fetches from a direct-mapped line store; misses fetch
//          a full 256-bit line from backing memory, install it, then respond.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   imem_addr/rmask        fetch request (rmask != 0 means request present)
//   imem_rdata/resp        one-cycle response with the requested word
//   bmem_addr/read         line refill request, held until bmem_resp
//   bmem_rdata/resp        refill line and completion
import rv32i_types::*;

module icache #(
  parameter int SETS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          imem_addr,
  input  logic [3:0]           imem_rmask,
  output logic [31:0]          imem_rdata,
  output logic                 imem_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  input  logic [LINE_BITS-1:0] bmem_rdata,
  input  logic                 bmem_resp
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS;

  icache_state_t state, state_next;
  logic [31:0]   req_addr;

  logic [IDX_BITS-1:0]  req_index;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 rd_valid;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 hit;
  logic                 fill;
  logic                 unused_addr_bits;

  assign req_index        = req_addr[OFFSET_BITS +: IDX_BITS];
  assign req_tag          = req_addr[31 -: TAG_BITS];
  assign unused_addr_bits = ^req_addr[1:0];

  icache_array #(
    .SETS     (SETS),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_line  (bmem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && |imem_rmask) begin
        req_addr <= imem_addr;
      end
    end
  end

  assign hit = rd_valid && (rd_tag == req_tag);

  always_comb begin
    state_next = state;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    bmem_read  = 1'b0;
    bmem_addr  = '0;
    fill       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|imem_rmask) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          imem_resp  = 1'b1;
          imem_rdata = rd_line[{req_addr[4:2], 5'b0} +: 32];
          state_next = IDLE;
        end else begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        bmem_read = 1'b1;
        bmem_addr = {req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        // The line lands at this edge, so the following LOOKUP hits.
        if (bmem_resp) begin
          fill       = 1'b1;
          state_next = LOOKUP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard testbench for icache
module tb_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  imem_addr;
  logic [3:0]   imem_rmask;
  logic [31:0]  imem_rdata;
  logic         imem_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic [255:0] bmem_rdata;
  logic         bmem_resp;

  int checks = 0;
  int errors = 0;
  int refills = 0;
  bit auto_bmem = 1'b1;

  logic [31:0] exp_q[$];
  logic [31:0] bexp_q[$];

  icache #(.SETS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_rdata (bmem_rdata),
    .bmem_resp  (bmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing-memory contents: word = address ^ A5A50000, except 0x60000004.
  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    logic [31:0]  a;
    for (int w = 0; w < 8; w++) begin
      a = base + 32'(w * 4);
      l[w*32 +: 32] = (a == 32'h6000_0004) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    end
    return l;
  endfunction

  // Response monitor: pops the scoreboard on every imem_resp.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (imem_resp) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_imem_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("imem_rdata", imem_rdata, e);
        end
      end else begin
        chk("rdata_zero_when_idle", imem_rdata, 32'd0);
      end
    end
  end

  // Backing-memory responder: checks refill address, answers 5 cycles later.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (auto_bmem && bmem_read && !rst) begin
        a = bmem_addr;
        if (bexp_q.size() == 0) chk("unexpected_refill", a, 32'hFFFF_FFFF);
        else chk("bmem_addr", a, bexp_q.pop_front());
        repeat (4) @(negedge clk);
        bmem_rdata = make_line(a);
        bmem_resp  = 1'b1;
        refills++;
        @(negedge clk);
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
      end
    end
  end

  // Called right after a negedge. lat: expected negedges until imem_resp (0 = skip).
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                       input bit miss, input int lat, input bit gap);
    int cyc = 0;
    int r0 = refills;
    exp_q.push_back(exp_data);
    if (miss) bexp_q.push_back({addr[31:5], 5'b0});
    imem_addr  = addr;
    imem_rmask = 4'hF;
    do begin
      @(negedge clk);
      cyc++;
    end while (!imem_resp && cyc < 200);
    if (!imem_resp) begin
      chk("resp_timeout", 32'(cyc), 32'd0);
      void'(exp_q.pop_back());
    end
    imem_rmask = 4'h0;
    if (lat != 0) chk("resp_latency", 32'(cyc), 32'(lat));
    chk("refill_count", 32'(refills - r0), miss ? 32'd1 : 32'd0);
    if (gap) @(negedge clk);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    imem_addr  = '0;
    imem_rmask = '0;
    bmem_rdata = '0;
    bmem_resp  = 1'b0;
    #1;
    chk("reset_imem_resp", 32'(imem_resp), 32'd0);
    chk("reset_imem_rdata", imem_rdata, 32'd0);
    chk("reset_bmem_read", 32'(bmem_read), 32'd0);
    chk("reset_bmem_addr", bmem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then hit on the same line.
    fetch(32'h6000_0004, 32'hDEAD_BEEF, 1'b1, 0, 1'b1);
    fetch(32'h6000_001C, 32'hC5A5_001C, 1'b0, 1, 1'b1);

    // Conflict eviction on index 0.
    fetch(32'h6000_0200, 32'hC5A5_0200, 1'b1, 0, 1'b1);
    fetch(32'h6000_0000, 32'hC5A5_0000, 1'b1, 0, 1'b1);

    // Back-to-back sequential fetch: one refill, then hits every other cycle.
    fetch(32'h6000_0020, 32'hC5A5_0020, 1'b1, 0, 1'b0);
    fetch(32'h6000_0024, 32'hC5A5_0024, 1'b0, 2, 1'b0);
    fetch(32'h6000_0028, 32'hC5A5_0028, 1'b0, 2, 1'b1);

    // Spurious bmem_resp in IDLE with a poisoned line: ignored.
    auto_bmem  = 1'b0;
    bmem_rdata = {8{32'h1111_1111}};
    bmem_resp  = 1'b1;
    repeat (2) @(negedge clk);
    chk("spurious_bmem_read", 32'(bmem_read), 32'd0);
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
    auto_bmem  = 1'b1;
    fetch(32'h6000_0004, 32'hDEAD_BEEF, 1'b0, 1, 1'b1);

    // Reset in the middle of a refill.
    auto_bmem  = 1'b0;
    imem_addr  = 32'h6000_0040;
    imem_rmask = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bmem_read && n < 20);
    chk("refill_started", 32'(bmem_read), 32'd1);
    chk("refill_addr", bmem_addr, 32'h6000_0040);
    #2 rst = 1'b1;
    #1;
    chk("rst_drops_bmem_read", 32'(bmem_read), 32'd0);
    chk("rst_bmem_addr", bmem_addr, 32'd0);
    imem_rmask = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    bmem_rdata = make_line(32'h6000_0040);
    bmem_resp  = 1'b1;
    repeat (2) @(negedge clk);
    chk("stale_resp_bmem_read", 32'(bmem_read), 32'd0);
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
    auto_bmem  = 1'b1;
    fetch(32'h6000_0040, 32'hC5A5_0040, 1'b1, 0, 1'b1);
    // Reset also invalidated the earlier lines.
    fetch(32'h6000_0004, 32'hDEAD_BEEF, 1'b1, 0, 1'b1);

    // Wrap-around: top address maps to the last index.
    fetch(32'hFFFF_FFE8, 32'h5A5A_FFE8, 1'b1, 0, 1'b1);
    fetch(32'hFFFF_FFE0, 32'h5A5A_FFE0, 1'b0, 1, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("refill_queue_drained", 32'(bexp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
